lti_observer: RTL
=================

Name: lti_observer

Overview:
- Discrete delta-operator Luenberger state observer for a 2-state, single-input, single-output plant.
- It runs in the reverse direction to the state-space filter: it consumes plant input u and measured plant output y, and reconstructs the state estimate x_hat and the predicted output y_hat.
- It uses a single time-multiplexed multiply-accumulate sequenced by an FSM, and the same ce_in/ce_out sample-strobe interface as the filter blocks.

Parameters:
- A_1_1, A_1_2, A_2_1, A_2_2, default 0: state matrix coefficients, signed CW-bit, CF fractional bits.
- B_1_1, B_2_1, default 0: input matrix coefficients.
- C_1_1, C_1_2, default 0: output matrix coefficients.
- L_1_1, L_2_1, default 0: observer gain coefficients.
- IW, 16: input sample width.
- OW, 16: output sample width.
- CW, 10: coefficient width.
- SW, 18: quantized state/operand width.
- RW, SW+CW+2: accumulator and long-state width (2 guard bits).
- CF, 9: coefficient fractional bits.
- DEL, 10: delta-operator right shift applied to dx.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- sig_u  in  IW  plant input sample, signed.
- sig_y  in  IW  plant measured output sample, signed.
- ce_in  in  1  sample strobe; one-cycle pulse.
- xhat_1  out  OW  state estimate 1, signed.
- xhat_2  out  OW  state estimate 2, signed.
- yhat  out  OW  predicted output, signed.
- ce_out  out  1  one-cycle pulse; outputs updated this cycle.
- busy  out  1  high while a sample is being processed.
- overrun  out  1  one-cycle pulse when ce_in arrives while busy.

Behaviour:
- Reset (asynchronous, rst_n low):
  - FSM goes to IDLE.
  - All long states, accumulator and operand registers clear to 0.
  - xhat_1, xhat_2, yhat, ce_out, busy and overrun are all 0.
- IDLE, ce_in=1:
  - Latch u=sext(sig_u) and y=sext(sig_y) to SW bits.
  - Latch xq_i = sat_SW(x_long_i >>> CF).
  - Clear acc; busy=1 from the next cycle; go to MAC_C.
- MAC_C (2 cycles):
  - acc += C_1_1*xq_1, then acc += C_1_2*xq_2.
  - Go to INNOV.
- INNOV (1 cycle):
  - yq = sat_SW(acc >>> CF).
  - e = sat_SW(y - yq).
  - Register yq for yhat; clear acc; go to MAC_X1.
- MAC_X1 (4 cycles):
  - acc accumulates A_1_1*xq_1, A_1_2*xq_2, B_1_1*u, L_1_1*e in that order.
  - On exit, dx_1 = acc; clear acc; go to MAC_X2.
- MAC_X2 (4 cycles):
  - Same sequence with row-2 coefficients A_2_1, A_2_2, B_2_1, L_2_1.
  - On exit, dx_2 = acc; go to UPDATE.
- UPDATE (1 cycle):
  - x_long_i <= sat_RW(x_long_i + (dx_i >>> DEL)), arithmetic shift.
  - Go to DONE.
- DONE (1 cycle):
  - ce_out=1.
  - xhat_i = sat_OW(x_long_i >>> CF), using the updated value.
  - yhat = sat_OW(yq).
  - busy=0 next cycle; return to IDLE.
- Latency: ce_in sampled at edge k gives ce_out high in the cycle following edge k+13. Throughput is 1 sample per 14 cycles.
- Outputs hold their values between ce_out pulses.
- Multiplier: signed CW x SW product, sign-extended into the RW accumulator; one product per cycle.
- All saturation is symmetric clip to the two's-complement max/min of the target width. Wrap-around is forbidden everywhere.
- ce_in while busy, including in the DONE cycle:
  - The sample is dropped; overrun pulses for 1 cycle.
  - The in-flight computation is unaffected.
- ce_in in the IDLE cycle immediately after DONE is accepted normally.
- Reset mid-operation aborts with no ce_out, and the state estimate returns to 0.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, MAC_C, INNOV, MAC_X1, MAC_X2, UPDATE, DONE).
  - Saturation function sat(value, width).
  - Default width constants.
- One sub-module: lti_mac — registered signed multiply-accumulate with clear, enable and operand inputs. The top level handles the coefficient/operand mux driven by the FSM and a step counter.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0; release -> busy stays 0 until ce_in.
- Latency: default params, single ce_in pulse -> exactly one ce_out, 14 cycles after ce_in; busy high for 14 cycles; outputs all 0.
- Gain path:
  - Setup: L_1_1=512 (1.0), DEL=0, other coefficients 0, sig_y=100, sig_u=0.
  - One sample -> xhat_1=100, xhat_2=0, yhat=0.
  - Second sample -> xhat_1=200.
- Output path:
  - Setup: additionally C_1_1=512.
  - After first sample (xhat_1=100), second sample with sig_y=100 -> yhat=100, e=0, xhat_1 stays 100.
- Overrun: ce_in pulses 5 cycles apart -> one overrun pulse, one ce_out, result equals the first sample's result.
- Saturation/reset: L_1_1=511, DEL=0, sig_y=32767 repeated -> xhat_1 clips at 32767 and never wraps negative; then rst_n low mid-MAC_X1 -> no ce_out, next sample starts from x=0.

Source files
------------

// File: rtl/lti_observer_pkg.sv
// Shared definitions for the delta-operator Luenberger observer: FSM encoding,
// default widths and a symmetric saturation helper.
package lti_observer_pkg;

  localparam int unsigned DEF_IW  = 16;
  localparam int unsigned DEF_OW  = 16;
  localparam int unsigned DEF_CW  = 10;
  localparam int unsigned DEF_SW  = 18;
  localparam int unsigned DEF_CF  = 9;
  localparam int unsigned DEF_DEL = 10;

  localparam int unsigned SAT_W = 64;
  typedef logic signed [SAT_W-1:0] wide_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC_C,
    S_INNOV,
    S_MAC_X1,
    S_MAC_X2,
    S_UPDATE,
    S_DONE
  } state_t;

  // Clip a wide signed value to the two's-complement range of a w-bit word.
  function automatic wide_t sat(input wide_t v, input int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/lti_mac.sv
// Registered signed multiply-accumulate: one CW x SW product per cycle into a
// saturating RW-bit accumulator.
module lti_mac
  import lti_observer_pkg::*;
#(
  parameter int unsigned CW = DEF_CW,
  parameter int unsigned SW = DEF_SW,
  parameter int unsigned RW = SW + CW + 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [CW-1:0] coef_i,
  input  logic [SW-1:0] opnd_i,
  output logic [RW-1:0] acc_o
);

  logic signed [CW+SW-1:0] prod;
  logic signed [RW-1:0]    acc_q;

  assign prod  = (CW+SW)'($signed(coef_i)) * (CW+SW)'($signed(opnd_i));
  assign acc_o = acc_q;

  // clr with en loads the product directly, starting a new sum in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr_i && en_i) begin
      acc_q <= RW'(prod);
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= RW'(sat(wide_t'(acc_q) + wide_t'(prod), RW));
    end
  end

endmodule

// File: rtl/lti_observer.sv
// 2-state SISO delta-operator Luenberger observer: reconstructs x_hat and y_hat
// from plant input u and measurement y using one time-shared MAC.
module lti_observer
  import lti_observer_pkg::*;
#(
  parameter int unsigned IW  = DEF_IW,
  parameter int unsigned OW  = DEF_OW,
  parameter int unsigned CW  = DEF_CW,
  parameter int unsigned SW  = DEF_SW,
  parameter int unsigned RW  = SW + CW + 2,
  parameter int unsigned CF  = DEF_CF,
  parameter int unsigned DEL = DEF_DEL,
  parameter logic signed [CW-1:0] A_1_1 = '0,
  parameter logic signed [CW-1:0] A_1_2 = '0,
  parameter logic signed [CW-1:0] A_2_1 = '0,
  parameter logic signed [CW-1:0] A_2_2 = '0,
  parameter logic signed [CW-1:0] B_1_1 = '0,
  parameter logic signed [CW-1:0] B_2_1 = '0,
  parameter logic signed [CW-1:0] C_1_1 = '0,
  parameter logic signed [CW-1:0] C_1_2 = '0,
  parameter logic signed [CW-1:0] L_1_1 = '0,
  parameter logic signed [CW-1:0] L_2_1 = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] sig_u,
  input  logic [IW-1:0] sig_y,
  input  logic          ce_in,
  output logic [OW-1:0] xhat_1,
  output logic [OW-1:0] xhat_2,
  output logic [OW-1:0] yhat,
  output logic          ce_out,
  output logic          busy,
  output logic          overrun
);

  state_t                state_q;
  logic [1:0]            step_q;
  logic signed [SW-1:0]  u_q, y_q, xq1_q, xq2_q, yq_q, e_q;
  logic signed [RW-1:0]  xl1_q, xl2_q, dx1_q;
  logic signed [OW-1:0]  xhat1_q, xhat2_q, yhat_q;
  logic                  ce_out_q, busy_q, overrun_q;

  logic signed [SW-1:0]  u_d, y_d, xq1_d, xq2_d, yq_d, e_d;
  logic signed [RW-1:0]  xl1_d, xl2_d;
  logic signed [OW-1:0]  xhat1_d, xhat2_d, yhat_d;

  logic                  mac_clr, mac_en;
  logic signed [CW-1:0]  coef;
  logic signed [SW-1:0]  opnd;
  logic signed [RW-1:0]  acc;

  lti_mac #(
    .CW(CW),
    .SW(SW),
    .RW(RW)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (mac_clr),
    .en_i   (mac_en),
    .coef_i (coef),
    .opnd_i (opnd),
    .acc_o  (acc)
  );

  // In UPDATE the accumulator still holds the complete row-2 sum, so it is dx_2.
  always_comb begin
    u_d     = SW'($signed(sig_u));
    y_d     = SW'($signed(sig_y));
    xq1_d   = SW'(sat(wide_t'(xl1_q >>> CF), SW));
    xq2_d   = SW'(sat(wide_t'(xl2_q >>> CF), SW));
    yq_d    = SW'(sat(wide_t'(acc >>> CF), SW));
    e_d     = SW'(sat(wide_t'(y_q) - wide_t'(yq_d), SW));
    xl1_d   = RW'(sat(wide_t'(xl1_q) + (wide_t'(dx1_q) >>> DEL), RW));
    xl2_d   = RW'(sat(wide_t'(xl2_q) + (wide_t'(acc) >>> DEL), RW));
    xhat1_d = OW'(sat(wide_t'(xl1_q >>> CF), OW));
    xhat2_d = OW'(sat(wide_t'(xl2_q >>> CF), OW));
    yhat_d  = OW'(sat(wide_t'(yq_q), OW));
  end

  always_comb begin
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    coef    = '0;
    opnd    = '0;
    case (state_q)
      S_IDLE, S_INNOV: mac_clr = 1'b1;
      S_MAC_C: begin
        mac_en = 1'b1;
        case (step_q)
          2'd0:    begin coef = C_1_1; opnd = xq1_q; end
          default: begin coef = C_1_2; opnd = xq2_q; end
        endcase
      end
      S_MAC_X1: begin
        mac_en = 1'b1;
        case (step_q)
          2'd0:    begin coef = A_1_1; opnd = xq1_q; end
          2'd1:    begin coef = A_1_2; opnd = xq2_q; end
          2'd2:    begin coef = B_1_1; opnd = u_q;   end
          default: begin coef = L_1_1; opnd = e_q;   end
        endcase
      end
      S_MAC_X2: begin
        // First row-2 product overwrites the row-1 sum as it is captured into dx_1.
        mac_en  = 1'b1;
        mac_clr = (step_q == 2'd0);
        case (step_q)
          2'd0:    begin coef = A_2_1; opnd = xq1_q; end
          2'd1:    begin coef = A_2_2; opnd = xq2_q; end
          2'd2:    begin coef = B_2_1; opnd = u_q;   end
          default: begin coef = L_2_1; opnd = e_q;   end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      step_q    <= '0;
      u_q       <= '0;
      y_q       <= '0;
      xq1_q     <= '0;
      xq2_q     <= '0;
      yq_q      <= '0;
      e_q       <= '0;
      xl1_q     <= '0;
      xl2_q     <= '0;
      dx1_q     <= '0;
      xhat1_q   <= '0;
      xhat2_q   <= '0;
      yhat_q    <= '0;
      ce_out_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      ce_out_q  <= 1'b0;
      overrun_q <= ce_in && (state_q != S_IDLE);
      busy_q    <= (state_q != S_IDLE) || ce_in;
      case (state_q)
        S_IDLE: begin
          if (ce_in) begin
            u_q     <= u_d;
            y_q     <= y_d;
            xq1_q   <= xq1_d;
            xq2_q   <= xq2_d;
            step_q  <= '0;
            state_q <= S_MAC_C;
          end
        end
        S_MAC_C: begin
          if (step_q == 2'd1) begin
            step_q  <= '0;
            state_q <= S_INNOV;
          end else begin
            step_q <= step_q + 2'd1;
          end
        end
        S_INNOV: begin
          yq_q    <= yq_d;
          e_q     <= e_d;
          step_q  <= '0;
          state_q <= S_MAC_X1;
        end
        S_MAC_X1: begin
          if (step_q == 2'd3) begin
            step_q  <= '0;
            state_q <= S_MAC_X2;
          end else begin
            step_q <= step_q + 2'd1;
          end
        end
        S_MAC_X2: begin
          if (step_q == 2'd0) dx1_q <= acc;
          if (step_q == 2'd3) begin
            step_q  <= '0;
            state_q <= S_UPDATE;
          end else begin
            step_q <= step_q + 2'd1;
          end
        end
        S_UPDATE: begin
          xl1_q   <= xl1_d;
          xl2_q   <= xl2_d;
          state_q <= S_DONE;
        end
        S_DONE: begin
          ce_out_q <= 1'b1;
          xhat1_q  <= xhat1_d;
          xhat2_q  <= xhat2_d;
          yhat_q   <= yhat_d;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign xhat_1  = xhat1_q;
  assign xhat_2  = xhat2_q;
  assign yhat    = yhat_q;
  assign ce_out  = ce_out_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule
